// File: rtl/multiplier_if.sv
// Micro-op encoding plus the decode->multiplier (d_x_if) and multiplier->writeback
// (x_w_if) valid/ready interfaces.
package multiplier_pkg;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_SLT,
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU
    } rv_uop;
endpackage

interface d_x_if #(parameter int unsigned p_seq_num_bits = 5);
    logic                                    val;
    logic                                    rdy;
    logic [multiplier_pkg::XLEN-1:0]         pc;
    logic [p_seq_num_bits-1:0]               seq_num;
    logic [multiplier_pkg::XLEN-1:0]         op1;
    logic [multiplier_pkg::XLEN-1:0]         op2;
    logic [multiplier_pkg::REG_ADDR_W-1:0]   waddr;
    multiplier_pkg::rv_uop                   uop;

    modport master (output val, pc, seq_num, op1, op2, waddr, uop, input rdy);
    modport slave  (input val, pc, seq_num, op1, op2, waddr, uop, output rdy);
endinterface

interface x_w_if #(parameter int unsigned p_seq_num_bits = 5);
    logic                                    val;
    logic                                    rdy;
    logic [multiplier_pkg::XLEN-1:0]         pc;
    logic [p_seq_num_bits-1:0]               seq_num;
    logic [multiplier_pkg::REG_ADDR_W-1:0]   waddr;
    logic [multiplier_pkg::XLEN-1:0]         wdata;
    logic                                    wen;

    modport master (output val, pc, seq_num, waddr, wdata, wen, input rdy);
    modport slave  (input val, pc, seq_num, waddr, wdata, wen, output rdy);
endinterface

// File: rtl/multiplier.sv
// Single-stage pipelined integer multiplier with one output register and valid/ready flow.
// Define MULTIPLIER_MULH_EN to add OP_MULH / OP_MULHSU / OP_MULHU (high-word products).
module multiplier
    import multiplier_pkg::*;
#(
    parameter int unsigned p_seq_num_bits = 5
) (
    input  logic  clk,
    input  logic  rst,
    d_x_if.slave  D,
    x_w_if.master W
);

    localparam int unsigned TRACE_W = 33;

    typedef struct packed {
        logic [XLEN-1:0]           pc;
        logic [p_seq_num_bits-1:0] seq_num;
        logic [REG_ADDR_W-1:0]     waddr;
        logic [XLEN-1:0]           wdata;
        logic                      wen;
    } w_msg_t;

    logic            out_valid;
    w_msg_t          out_q;
    w_msg_t          msg_c;
    logic            d_xfer_c;
    logic            w_xfer_c;
    logic [XLEN-1:0] wdata_c;
    logic            wen_c;

    // Accept whenever the register is empty or is being drained this cycle.
    assign D.rdy    = !out_valid || W.rdy;
    assign d_xfer_c = D.val && D.rdy;
    assign w_xfer_c = out_valid && W.rdy;

`ifdef MULTIPLIER_MULH_EN
    logic [2*XLEN-1:0] op1_ext_c;
    logic [2*XLEN-1:0] op2_ext_c;
    logic [2*XLEN-1:0] prod_c;

    // Extend each operand to 64 bits by signedness; the low 64 bits of the product
    // are then exact for every signedness combination, and its low word serves OP_MUL.
    always_comb begin
        op1_ext_c = {{XLEN{D.op1[XLEN-1]}}, D.op1};
        op2_ext_c = {{XLEN{D.op2[XLEN-1]}}, D.op2};
        case (D.uop)
            OP_MULHSU: op2_ext_c = {XLEN'(0), D.op2};
            OP_MULHU: begin
                op1_ext_c = {XLEN'(0), D.op1};
                op2_ext_c = {XLEN'(0), D.op2};
            end
            default: ;
        endcase
    end

    assign prod_c = op1_ext_c * op2_ext_c;

    always_comb begin
        wdata_c = '0;
        wen_c   = 1'b0;
        case (D.uop)
            OP_MUL: begin
                wdata_c = prod_c[XLEN-1:0];
                wen_c   = 1'b1;
            end
            OP_MULH, OP_MULHSU, OP_MULHU: begin
                wdata_c = prod_c[2*XLEN-1:XLEN];
                wen_c   = 1'b1;
            end
            default: ;
        endcase
    end
`else
    logic [XLEN-1:0] prod_c;

    // Low word of the product is independent of operand signedness.
    assign prod_c = D.op1 * D.op2;

    always_comb begin
        wdata_c = '0;
        wen_c   = 1'b0;
        case (D.uop)
            OP_MUL: begin
                wdata_c = prod_c;
                wen_c   = 1'b1;
            end
            default: ;
        endcase
    end
`endif

    always_comb begin
        msg_c         = '0;
        msg_c.pc      = D.pc;
        msg_c.seq_num = D.seq_num;
        msg_c.waddr   = D.waddr;
        msg_c.wdata   = wdata_c;
        msg_c.wen     = wen_c;
    end

    // Output register: a new accept overwrites (and keeps valid), a lone drain clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (d_xfer_c) begin
            out_valid <= 1'b1;
            out_q     <= msg_c;
        end else if (w_xfer_c) begin
            out_valid <= 1'b0;
        end
    end

    assign W.val     = out_valid;
    assign W.pc      = out_q.pc;
    assign W.seq_num = out_q.seq_num;
    assign W.waddr   = out_q.waddr;
    assign W.wdata   = out_q.wdata;
    assign W.wen     = out_q.wen;

    // Fixed-width text of the message being accepted this cycle, blanks when idle.
    function automatic string trace();
        string s;
        if (D.val && D.rdy) begin
            s = $sformatf("%h|%h|%h|%h|%h", D.pc, 12'(D.seq_num), 8'(D.waddr), D.op1, D.op2);
        end else begin
            s = "";
            for (int i = 0; i < TRACE_W; i++) s = {s, " "};
        end
        return s;
    endfunction

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier: directed steps in one initial block, results checked
// at every W transfer against a queue of expectations pushed at D accept time.
module tb_multiplier #(
    parameter int unsigned SEQ_W = 5
);
    import multiplier_pkg::*;

`ifdef MULTIPLIER_MULH_EN
    localparam bit MULH = 1'b1;
`else
    localparam bit MULH = 1'b0;
`endif

    typedef struct {
        logic [31:0]      pc;
        logic [SEQ_W-1:0] seq;
        logic [4:0]       waddr;
        logic [31:0]      wdata;
        logic             wen;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   xfer_cyc[$];
    logic [SEQ_W-1:0] seq_n = '0;
    bit   rnd_done;

    d_x_if #(.p_seq_num_bits(SEQ_W)) d_if ();
    x_w_if #(.p_seq_num_bits(SEQ_W)) w_if ();

    multiplier #(.p_seq_num_bits(SEQ_W)) dut (
        .clk (clk),
        .rst (rst),
        .D   (d_if),
        .W   (w_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result: wide arithmetic on explicitly extended operands.
    function automatic void model(input rv_uop u, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] wd, output logic wen);
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        wd  = '0;
        wen = 1'b0;
        p   = '0;
        case (u)
            OP_MUL: begin
                p = {32'd0, a} * {32'd0, b};
                wd = p[31:0]; wen = 1'b1;
            end
`ifdef MULTIPLIER_MULH_EN
            OP_MULH: begin
                sa = longint'($signed(a)); sbv = longint'($signed(b));
                p = 64'(sa * sbv); wd = p[63:32]; wen = 1'b1;
            end
            OP_MULHSU: begin
                sa = longint'($signed(a)); sbv = longint'({32'd0, b});
                p = 64'(sa * sbv); wd = p[63:32]; wen = 1'b1;
            end
            OP_MULHU: begin
                p = {32'd0, a} * {32'd0, b};
                wd = p[63:32]; wen = 1'b1;
            end
`endif
            default: ;
        endcase
    endfunction

    // Drive one message; push its expectation on the cycle it is accepted.
    task automatic send(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input rv_uop u,
                        input logic [31:0] ew, input logic ewen, input bit chk_rdy);
        exp_t e;
        bit   ok = 1'b0;
        d_if.val = 1'b1; d_if.pc = pc; d_if.seq_num = seq_n; d_if.op1 = a; d_if.op2 = b;
        d_if.waddr = wa; d_if.uop = u;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (chk_rdy && i == 0) check("b2b_d_rdy", 64'(d_if.rdy), 64'(1));
            if (d_if.rdy) begin
                e.pc = pc; e.seq = seq_n; e.waddr = wa; e.wdata = ew; e.wen = ewen;
                sb.push_back(e);
                ok = 1'b1;
            end
        end
        check("send_accept", 64'(ok), 64'(1));
        @(posedge clk); #1;
        d_if.val = 1'b0;
        seq_n = seq_n + 1'b1;
    endtask

    task automatic send_model(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] wa, input rv_uop u);
        logic [31:0] wd;
        logic        we;
        model(u, a, b, wd, we);
        send(pc, a, b, wa, u, wd, we, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    // Monitor: a W transfer happens at the next posedge when val && rdy at the negedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && w_if.val && w_if.rdy) begin
            check("no_spurious_xfer", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("w_pc",    64'(w_if.pc),      64'(e.pc));
                check("w_seq",   64'(w_if.seq_num), 64'(e.seq));
                check("w_waddr", 64'(w_if.waddr),   64'(e.waddr));
                check("w_wdata", 64'(w_if.wdata),   64'(e.wdata));
                check("w_wen",   64'(w_if.wen),     64'(e.wen));
            end
            xfer_cyc.push_back(cyc);
        end
    end

    initial begin
        rst = 1'b1;
        d_if.val = 1'b0; d_if.pc = '0; d_if.seq_num = '0; d_if.op1 = '0; d_if.op2 = '0;
        d_if.waddr = '0; d_if.uop = OP_NOP;
        w_if.rdy = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_w_val",   64'(w_if.val),   64'(0));
        check("rst_d_rdy",   64'(d_if.rdy),   64'(1));
        check("rst_w_pc",    64'(w_if.pc),    64'(0));
        check("rst_w_wdata", 64'(w_if.wdata), 64'(0));
        check("rst_w_wen",   64'(w_if.wen),   64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic, overflow, unsupported op
        seq_n = SEQ_W'(1);
        send(32'h200, 32'd3, 32'd4, 5'd5, OP_MUL, 32'd12, 1'b1, 1'b0);
        send(32'h204, 32'hFFFF_FFFF, 32'd5, 5'd6, OP_MUL, 32'hFFFF_FFFB, 1'b1, 1'b0);
        send(32'h208, 32'h0001_0000, 32'h0001_0000, 5'd7, OP_MUL, 32'h0, 1'b1, 1'b0);
        send(32'h20C, 32'd7, 32'd9, 5'd8, OP_ADD, 32'h0, 1'b0, 1'b0);

        // High-word ops: known products or zero/no-write when not configured
        send(32'h210, 32'hFFFF_FFFF, 32'd5, 5'd9,  OP_MULH,   MULH ? 32'hFFFF_FFFF : 32'h0, MULH, 1'b0);
        send(32'h214, 32'hFFFF_FFFF, 32'd5, 5'd10, OP_MULHSU, MULH ? 32'hFFFF_FFFF : 32'h0, MULH, 1'b0);
        send(32'h218, 32'hFFFF_FFFF, 32'd5, 5'd11, OP_MULHU,  MULH ? 32'h0000_0004 : 32'h0, MULH, 1'b0);
        send(32'h21C, 32'h8000_0000, 32'h8000_0000, 5'd12, OP_MULH,   MULH ? 32'h4000_0000 : 32'h0, MULH, 1'b0);
        send(32'h220, 32'h8000_0000, 32'h8000_0000, 5'd13, OP_MULHSU, MULH ? 32'hC000_0000 : 32'h0, MULH, 1'b0);
        send(32'h224, 32'h8000_0000, 32'h8000_0000, 5'd14, OP_MULHU,  MULH ? 32'h4000_0000 : 32'h0, MULH, 1'b0);
        drain();

        // Back-to-back: four accepts and four transfers on consecutive cycles
        xfer_cyc.delete();
        for (int k = 0; k < 4; k++)
            send(32'h400 + 32'(4 * k), 32'(k + 2), 32'(k + 10), 5'(k + 1), OP_MUL,
                 32'((k + 2) * (k + 10)), 1'b1, 1'b1);
        drain();
        check("b2b_count", 64'(xfer_cyc.size()), 64'(4));
        for (int k = 0; k + 1 < xfer_cyc.size(); k++)
            check("b2b_consecutive", 64'(xfer_cyc[k+1] - xfer_cyc[k]), 64'(1));

        // Backpressure: output holds while W.rdy=0, then drains
        w_if.rdy = 1'b0;
        send(32'h300, 32'd6, 32'd7, 5'd3, OP_MUL, 32'd42, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_w_val",   64'(w_if.val),   64'(1));
            check("bp_w_pc",    64'(w_if.pc),    64'(32'h300));
            check("bp_w_wdata", 64'(w_if.wdata), 64'(42));
            check("bp_d_rdy",   64'(d_if.rdy),   64'(0));
        end
        @(posedge clk); #1;
        w_if.rdy = 1'b1;
        @(negedge clk);
        check("bp_release_d_rdy", 64'(d_if.rdy), 64'(1));
        drain();

        // Random send gaps and random receive stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [31:0] a;
                    logic [31:0] b;
                    rv_uop       u;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    a = $urandom; b = $urandom;
                    case ($urandom_range(0, 4))
                        0: u = OP_MUL;
                        1: u = OP_MULH;
                        2: u = OP_MULHSU;
                        3: u = OP_MULHU;
                        default: u = OP_XOR;
                    endcase
                    send_model($urandom, a, b, 5'($urandom), u);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    w_if.rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        w_if.rdy = 1'b1;
        drain();

        // Reset while a result is pending: discarded, never transferred
        w_if.rdy = 1'b0;
        send(32'h500, 32'd11, 32'd13, 5'd20, OP_MUL, 32'd143, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_w_val", 64'(w_if.val), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_w_val",   64'(w_if.val),   64'(0));
        check("async_rst_d_rdy",   64'(d_if.rdy),   64'(1));
        check("async_rst_w_wdata", 64'(w_if.wdata), 64'(0));
        check("async_rst_w_pc",    64'(w_if.pc),    64'(0));
        sb.delete();
        d_if.val = 1'b1; d_if.pc = 32'h600; d_if.op1 = 32'd2; d_if.op2 = 32'd2; d_if.uop = OP_MUL;
        repeat (2) @(posedge clk);
        @(negedge clk);
        d_if.val = 1'b0;
        rst = 1'b0;
        w_if.rdy = 1'b1;
        xfer_cyc.delete();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_w_val",    64'(w_if.val),        64'(0));
        check("post_rst_no_xfer",  64'(xfer_cyc.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
